// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared defaults and helpers for the pipelined shift register.
//                PIPE_WIDTH  - default bits per stage word
//                PIPE_DEPTH  - default number of stages
//                PIPE_BUBBLE - default word written into emptied stages
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int          PIPE_WIDTH  = 32;
    localparam int          PIPE_DEPTH  = 4;
    localparam logic [31:0] PIPE_BUBBLE = 32'h0000_0013;

    // Per-edge action of a single stage register.
    typedef enum logic [1:0] {
        STAGE_RETAIN = 2'd0,
        STAGE_BUBBLE = 2'd1,
        STAGE_LOAD   = 2'd2
    } stage_op_e;

    // Population count over up to 8 valid flags (DEPTH never exceeds 8).
    function automatic logic [3:0] pipe_popcount(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage
//  Description : One pipeline stage register (data word + valid flag).
//                Priority: clear -> bubble, else hold -> retain,
//                else load -> capture d/d_valid, else retain.
//  Ports       : clk      - clock, rising edge
//                reset    - asynchronous active-low reset
//                hold     - keep current content
//                clear    - load BUBBLE with valid 0
//                load     - capture d / d_valid
//                d        - incoming word
//                d_valid  - incoming valid flag
//                q        - registered word
//                q_valid  - registered valid flag
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = PIPE_WIDTH,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(PIPE_BUBBLE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    stage_op_e        w_op;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    always_comb begin
        w_op = STAGE_RETAIN;
        if (clear) begin
            w_op = STAGE_BUBBLE;
        end else if (!hold && load) begin
            w_op = STAGE_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= BUBBLE;
            r_valid <= 1'b0;
        end else begin
            case (w_op)
                STAGE_BUBBLE: begin
                    r_data  <= BUBBLE;
                    r_valid <= 1'b0;
                end
                STAGE_LOAD: begin
                    r_data  <= d;
                    r_valid <= d_valid;
                end
                default: begin
                end
            endcase
        end
    end

    assign q       = r_data;
    assign q_valid = r_valid;

endmodule : pipe_stage
`default_nettype wire

// File: rtl/pipe_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_shift_reg
//  Description : DEPTH-stage pipelined shift register with per-stage stall
//                and flush, bubble insertion behind stalled stages and a
//                combinational occupancy count.
//  Ports       : clk       - clock, rising edge
//                reset     - asynchronous active-low reset
//                advance   - global shift enable
//                in        - word entering stage 0
//                in_valid  - in carries a real word
//                stall     - bit k holds stage k (and all earlier stages)
//                flush     - bit k empties stage k
//                data_o    - stage k word at [k*WIDTH +: WIDTH]
//                valid_o   - stage k valid flag
//                in_ready  - stage 0 accepts in this cycle
//                occupancy - number of valid stages
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_shift_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = PIPE_WIDTH,
    parameter int               DEPTH  = PIPE_DEPTH,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(PIPE_BUBBLE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       advance,
    input  logic [WIDTH-1:0]           in,
    input  logic                       in_valid,
    input  logic [DEPTH-1:0]           stall,
    input  logic [DEPTH-1:0]           flush,
    output logic [DEPTH*WIDTH-1:0]     data_o,
    output logic [DEPTH-1:0]           valid_o,
    output logic                       in_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] w_hold;
    logic [DEPTH-1:0] w_stage_hold;
    logic [DEPTH-1:0] w_clear;
    logic [DEPTH-1:0] w_load;

    // A stall at stage j backs up every stage k <= j, so hold[k] is the
    // OR of stall[k..DEPTH-1].
    always_comb begin
        w_hold = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_hold[k] = |(stall >> k);
        end
    end

    // Stage k moves only when advancing and nothing downstream is stalled.
    // When its upstream neighbour is stalled it receives a bubble instead
    // of a copy; flush overrides everything.
    always_comb begin
        w_stage_hold = '0;
        w_clear      = '0;
        w_load       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_stage_hold[k] = ~advance | w_hold[k];
            w_load[k]       = advance & ~w_hold[k];
            w_clear[k]      = flush[k];
            if (k > 0) begin
                w_clear[k] = flush[k] | (w_load[k] & stall[k-1]);
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] w_d;
        logic             w_d_valid;

        if (k == 0) begin : g_head
            assign w_d       = in;
            assign w_d_valid = in_valid;
        end else begin : g_body
            assign w_d       = data_o[(k-1)*WIDTH +: WIDTH];
            assign w_d_valid = valid_o[k-1];
        end

        pipe_stage #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .hold    (w_stage_hold[k]),
            .clear   (w_clear[k]),
            .load    (w_load[k]),
            .d       (w_d),
            .d_valid (w_d_valid),
            .q       (data_o[k*WIDTH +: WIDTH]),
            .q_valid (valid_o[k])
        );
    end

    assign in_ready  = advance & ~w_hold[0] & ~flush[0];
    assign occupancy = OCC_W'(pipe_popcount(8'(valid_o)));

endmodule : pipe_shift_reg
`default_nettype wire

// File: tb/tb_pipe_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_shift_reg
//  Description : Directed self-checking bench for pipe_shift_reg
//                (WIDTH=32, DEPTH=4, BUBBLE=32'h13).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_shift_reg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] BUB = 32'h0000_0013;

    logic                   clk;
    logic                   reset;
    logic                   advance;
    logic [WIDTH-1:0]       in;
    logic                   in_valid;
    logic [DEPTH-1:0]       stall;
    logic [DEPTH-1:0]       flush;
    logic [DEPTH*WIDTH-1:0] data_o;
    logic [DEPTH-1:0]       valid_o;
    logic                   in_ready;
    logic [2:0]             occupancy;

    int n_tests;
    int n_fail;

    pipe_shift_reg #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .BUBBLE (BUB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .advance   (advance),
        .in        (in),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .in_ready  (in_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Check full pipe state: stage words listed stage3..stage0.
    task automatic check_pipe(input string tag,
                              input logic [31:0] s3, input logic [31:0] s2,
                              input logic [31:0] s1, input logic [31:0] s0,
                              input logic [3:0] vld, input logic [2:0] occ);
        check_value({tag, "_data"}, 128'(data_o), {s3, s2, s1, s0});
        check_value({tag, "_valid"}, 128'(valid_o), 128'(vld));
        check_value({tag, "_occ"}, 128'(occupancy), 128'(occ));
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic adv, input logic [31:0] word,
                         input logic vld, input logic [3:0] stl,
                         input logic [3:0] fl);
        advance  = adv;
        in       = word;
        in_valid = vld;
        stall    = stl;
        flush    = fl;
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b0;
        advance  = 1'b0;
        in       = '0;
        in_valid = 1'b0;
        stall    = '0;
        flush    = '0;

        // Reset state, including an edge while reset is held.
        edge_step();
        check_pipe("reset", BUB, BUB, BUB, BUB, 4'b0000, 3'd0);
        check_value("reset_rdy_idle", 128'(in_ready), 128'(1'b0));
        drive(1'b1, 32'hEE, 1'b1, 4'b0000, 4'b0000);
        check_value("reset_rdy_adv", 128'(in_ready), 128'(1'b1));
        edge_step();
        check_pipe("reset_hold", BUB, BUB, BUB, BUB, 4'b0000, 3'd0);
        reset = 1'b1;

        // Fill: A1..A4, one per edge; latency k+1 to stage k.
        drive(1'b1, 32'hA1, 1'b1, 4'b0000, 4'b0000);
        edge_step();
        check_pipe("fill1", BUB, BUB, BUB, 32'hA1, 4'b0001, 3'd1);
        drive(1'b1, 32'hA2, 1'b1, 4'b0000, 4'b0000);
        edge_step();
        drive(1'b1, 32'hA3, 1'b1, 4'b0000, 4'b0000);
        edge_step();
        drive(1'b1, 32'hA4, 1'b1, 4'b0000, 4'b0000);
        edge_step();
        check_pipe("fill4", 32'hA1, 32'hA2, 32'hA3, 32'hA4, 4'b1111, 3'd4);

        // Stall stage 2: stages 0..2 hold, stage 3 takes a bubble.
        drive(1'b1, 32'hA5, 1'b1, 4'b0100, 4'b0000);
        check_value("stall_rdy", 128'(in_ready), 128'(1'b0));
        edge_step();
        check_pipe("stall2", BUB, 32'hA2, 32'hA3, 32'hA4, 4'b0111, 3'd3);

        // Refill, then flush 0/1 while stall 0 on the same edge.
        drive(1'b1, 32'hA5, 1'b1, 4'b0000, 4'b0000);
        edge_step();
        check_pipe("refill", 32'hA2, 32'hA3, 32'hA4, 32'hA5, 4'b1111, 3'd4);
        drive(1'b1, 32'hA6, 1'b1, 4'b0001, 4'b0011);
        check_value("flush_rdy", 128'(in_ready), 128'(1'b0));
        edge_step();
        check_pipe("flush", 32'hA3, 32'hA4, BUB, BUB, 4'b1100, 3'd2);

        // Flushed stages refill from upstream on the next advance.
        drive(1'b1, 32'hA7, 1'b1, 4'b0000, 4'b0000);
        edge_step();
        check_pipe("post_flush", 32'hA4, BUB, BUB, 32'hA7, 4'b1001, 3'd2);

        // advance=0 for three edges with in changing.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'hB1 + 32'(i), 1'b1, 4'b0000, 4'b0000);
            check_value("noadv_rdy", 128'(in_ready), 128'(1'b0));
            edge_step();
        end
        check_pipe("noadv", 32'hA4, BUB, BUB, 32'hA7, 4'b1001, 3'd2);

        // in_valid=0 still loads the data word.
        drive(1'b1, 32'hFF, 1'b0, 4'b0000, 4'b0000);
        edge_step();
        check_pipe("invalid_in", BUB, BUB, 32'hA7, 32'hFF, 4'b0010, 3'd1);

        // All stalls set: everything holds.
        drive(1'b1, 32'hC0, 1'b1, 4'b1111, 4'b0000);
        check_value("allstall_rdy", 128'(in_ready), 128'(1'b0));
        edge_step();
        check_pipe("allstall", BUB, BUB, 32'hA7, 32'hFF, 4'b0010, 3'd1);

        // Stream through; stage 3 content drops off the end.
        drive(1'b1, 32'hC1, 1'b1, 4'b0000, 4'b0000);
        edge_step();
        check_pipe("drain1", BUB, 32'hA7, 32'hFF, 32'hC1, 4'b0101, 3'd2);
        drive(1'b1, 32'hC2, 1'b1, 4'b0000, 4'b0000);
        edge_step();
        drive(1'b1, 32'hC3, 1'b1, 4'b0000, 4'b0000);
        edge_step();
        check_pipe("drain3", 32'hFF, 32'hC1, 32'hC2, 32'hC3, 4'b0111, 3'd3);

        // Asynchronous reset between edges during streaming.
        drive(1'b1, 32'hC4, 1'b1, 4'b0000, 4'b0000);
        edge_step();
        #2;
        reset = 1'b0;
        #1;
        check_pipe("async_rst", BUB, BUB, BUB, BUB, 4'b0000, 3'd0);
        edge_step();
        #2;
        reset = 1'b1;
        drive(1'b1, 32'hD1, 1'b1, 4'b0000, 4'b0000);
        edge_step();
        check_pipe("after_rst", BUB, BUB, BUB, 32'hD1, 4'b0001, 3'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_shift_reg
`default_nettype wire

// File: doc/pipe_shift_reg.md
PIPE_SHIFT_REG -- requirements
Module: pipe_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: bits per stage word.
REQ-002 The block SHALL have parameter DEPTH, default 4, legal range 2..8: number of pipeline stages.
REQ-003 The block SHALL have parameter BUBBLE, default 32'h0000_0013, width WIDTH: data value written into any emptied stage.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 The block SHALL have port advance, input, 1 bit: global shift enable.
REQ-007 The block SHALL have port in, input, WIDTH bits: word entering stage 0.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in carries a real instruction/word.
REQ-009 The block SHALL have port stall, input, DEPTH bits: bit k holds stage k.
REQ-010 The block SHALL have port flush, input, DEPTH bits: bit k empties stage k.
REQ-011 The block SHALL have port data_o, output, DEPTH*WIDTH bits: stage k word at bits [k*WIDTH +: WIDTH].
REQ-012 The block SHALL have port valid_o, output, DEPTH bits: stage k valid flag.
REQ-013 The block SHALL have port in_ready, output, 1 bit: stage 0 accepts in this cycle.
REQ-014 The block SHALL have port occupancy, output, $clog2(DEPTH+1) bits: count of set valid_o bits.

Function
REQ-015 hold[k] SHALL equal OR of stall[j] for j = k..DEPTH-1; a stall at a later stage backs up every earlier stage.
REQ-016 Per rising edge, stage k SHALL update by first matching rule: flush[k] -> data BUBBLE, valid 0; else !advance or hold[k] -> retain; else k>0 and stall[k-1] -> data BUBBLE, valid 0 (bubble insertion); else k=0 -> data in, valid in_valid; else -> copy stage k-1 data and valid.
REQ-017 Flush SHALL override stall and advance for the same stage; stage k flushed while stage k-1 advances loses its old content and then receives stage k-1 content on the next advancing edge.
REQ-018 in_ready SHALL equal advance & ~hold[0] & ~flush[0], purely combinational.
REQ-019 in with in_valid=0 SHALL still load on an advancing edge, giving valid 0 with that data.
REQ-020 data_o, valid_o SHALL be driven directly from registers (zero combinational path from inputs); latency in to stage k output SHALL be k+1 advancing edges with no stalls.
REQ-021 occupancy SHALL be combinational popcount of valid_o, range 0..DEPTH, never wrapping.
REQ-022 All stall bits set with advance=1 SHALL hold every stage; stage DEPTH-1 output SHALL be discarded on its next advance (no overflow indication).

Reset
REQ-023 While reset=0 every stage SHALL hold data BUBBLE and valid 0, asynchronously, irrespective of clk.
REQ-024 Reset values SHALL be: data_o all BUBBLE, valid_o 0, occupancy 0, in_ready = advance & ~hold[0] & ~flush[0].
REQ-025 Reset asserted mid-shift SHALL discard all in-flight words; first advancing edge after release SHALL load only stage 0.

Structure
REQ-026 Defaults PIPE_WIDTH=32, PIPE_DEPTH=4, PIPE_BUBBLE=32'h0000_0013 SHALL live in package pipe_pkg.
REQ-027 One sub-module pipe_stage (ports clk, reset, hold, clear, load, d, d_valid, q, q_valid) SHALL implement one stage, instantiated DEPTH times in a generate loop.
REQ-028 The block SHALL be synthesizable, with no latches and no blocking assignments in sequential logic.

Verification (WIDTH=32, DEPTH=4)
REQ-029 Reset, then advance=1, in=0xA1,0xA2,0xA3,0xA4 with in_valid=1, no stall/flush -> after 4 edges data_o stages 0..3 = A4,A3,A2,A1, valid_o=4'b1111, occupancy=4.
REQ-030 Full pipe, stall=4'b0100 for one edge -> stages 0..2 unchanged, stage 3 = BUBBLE with valid 0, occupancy=3, in_ready=0.
REQ-031 Full pipe, flush=4'b0011 with stall=4'b0001 on same edge -> stages 0,1 = BUBBLE valid 0, stage 2 = old stage 1, stage 3 = old stage 2.
REQ-032 advance=0 for 3 edges with in changing -> all registers unchanged, in_ready=0.
REQ-033 Reset asserted between clock edges during streaming -> data_o immediately all 0x13, valid_o=0, occupancy=0 before the next edge.
REQ-034 in_valid=0, in=0xFF on advancing edge -> stage 0 data 0xFF, valid 0, occupancy excludes it.
